lcd_frame_monitor: RTL and testbench
====================================

# lcd_frame_monitor

- Receive-side checker for the parallel RGB565 LCD interface that the renderer drives (DE, HSYNC, VSYNC, R/G/B at the pixel clock).
- Per frame, it measures active pixels per line and active lines per frame, flags geometry errors, and computes a CRC over all active pixels.
- Sits beside the console top level on the LCD pins, for on-board self-test and for bench regression of every game mode. Observes only; never drives the LCD.

## Interface

Parameters:
- H_ACTIVE, 480: required DE-high pixels per line.
- V_ACTIVE, 272: required DE lines per frame.
- LOCK_FRAMES, 2: consecutive error-free frames before `locked` asserts (1..15).
- SYNC_ACTIVE_LOW, 1: 1 means HSYNC/VSYNC are asserted low.

Ports:
- clk_pix  in  1  pixel clock (9 MHz); one clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- lcd_de  in  1  data enable.
- lcd_hsync  in  1  horizontal sync.
- lcd_vsync  in  1  vertical sync.
- lcd_r  in  5  red.
- lcd_g  in  6  green.
- lcd_b  in  5  blue.
- frame_done  out  1  one-cycle pulse; result outputs updated this cycle.
- frame_crc  out  16  CRC of the last completed frame.
- frame_lines  out  9  DE lines counted in the last frame (saturating).
- err_hlen  out  1  last frame had at least one line with pixel count ≠ H_ACTIVE.
- err_vlen  out  1  last frame had line count ≠ V_ACTIVE.
- locked  out  1  LOCK_FRAMES consecutive clean frames have been seen.
- frame_count  out  8  completed-frame counter; wraps 255→0.

## Operation

- Input stage: all LCD inputs are registered once (stage S1), then the previous value is kept (S2). Edges are detected as S1 versus S2.
- Polarity: VSYNC and HSYNC are normalised to active-high using SYNC_ACTIVE_LOW. HSYNC is registered but not used for checking; line boundaries come from DE falling edges.
- States:
  - IDLE: entered on reset. On the first VSYNC assert edge, go to FRAME. Nothing is published.
  - FRAME: accumulate. On each VSYNC assert edge, publish results, clear the accumulators, and stay in FRAME.
- Pixel counter (10 bits, saturates at 1023):
  - Increments on each S1 cycle with DE=1.
  - On a DE falling edge, the line closes: compare the count with H_ACTIVE (mismatch sets sticky hlen_acc), increment the line counter (9 bits, saturates at 511), and clear the pixel counter.
- Open line at VSYNC: if DE is still high at the VSYNC assert edge, that line is closed and counted in the same cycle before publishing.
- Publish:
  - frame_crc ← crc_acc.
  - frame_lines ← line counter.
  - err_hlen ← hlen_acc.
  - err_vlen ← (lines ≠ V_ACTIVE).
  - frame_count increments.
  - frame_done pulses.
- Lock counter (4 bits):
  - A clean frame increments it, saturating at LOCK_FRAMES; `locked` is high when it equals LOCK_FRAMES.
  - Any error clears the counter and drops `locked` on the same publish cycle.
- Simultaneous DE pixel and VSYNC edge: the pixel is counted and CRC'd into the closing frame.
- Reset mid-frame: all state and outputs clear; the partial frame is discarded; the monitor returns to IDLE.

## Timing

- Reset values: frame_done=0, frame_crc=0x0000, frame_lines=0, err_hlen=0, err_vlen=0, locked=0, frame_count=0.
- Latency: a VSYNC assert present at the port before clock edge N produces frame_done=1 in the cycle after edge N+1 (2 clocks). Result outputs change on the same edge and hold until the next publish.
- frame_done is exactly one cycle wide. It is never asserted out of IDLE.
- CRC throughput: one pixel per clock, no stalls. The CRC update is a single-cycle combinational step on the S1 pixel.

## Configuration

- Macro: LCD_MON_CRC_EN.
- Defined: CRC-16/CCITT-FALSE runs over each active pixel, taken as a 16-bit word {r,g,b} processed MSB first.
  - Polynomial 0x1021, initial value 0xFFFF, no reflection, no final XOR.
  - crc_acc re-initialises to 0xFFFF at each publish.
- Undefined: no CRC logic is compiled in; frame_crc is constant 0x0000. All other behaviour is unchanged.

## Structure

- Shared package lcd_mon_pkg:
  - CRC_POLY=16'h1021, CRC_INIT=16'hFFFF.
  - Counter widths: PIX_W=10, LINE_W=9.
  - The state enum {IDLE, FRAME}.
- One sub-module, crc16_ccitt_w16: combinational next-CRC from (crc_in, data16). Instantiated only under LCD_MON_CRC_EN.

## Test plan

- Reset, then two frames of 480×272 with DE correct and all pixels 0x0000 → first VSYNC gives no pulse. Second VSYNC gives frame_done, frame_lines=272, err_hlen=0, err_vlen=0, frame_count=1, frame_crc equal to the software model's value for 130560 zero words.
- H_ACTIVE=4, V_ACTIVE=2, pixels 0x1234, 0x5678, 0x9ABC, 0xDEF0 per line → frame_crc matches the model and is reproduced exactly on the next frame. With LCD_MON_CRC_EN undefined, frame_crc=0x0000.
- Line 100 has 479 pixels → err_hlen=1, err_vlen=0, locked drops on that publish. The next two clean frames → locked=1 on the second publish.
- A frame with 273 lines, then a frame with DE still high (3 pixels) at the VSYNC edge under H_ACTIVE=4 → err_vlen=1 (frame_lines=273); then frame_lines counts the open line and err_hlen=1.
- rst_n pulsed low mid-frame (line 50) → all outputs go to 0 immediately. The next VSYNC produces no frame_done; the following one publishes a full frame.
- 256 clean frames → frame_count wraps to 0; locked stays 1 throughout.

Source files
------------

// File: rtl/lcd_mon_pkg.sv
// Shared definitions for the LCD frame monitor: CRC constants, counter widths and FSM states.
package lcd_mon_pkg;
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam int          PIX_W    = 10;
  localparam int          LINE_W   = 9;

  typedef enum logic {
    IDLE,
    FRAME
  } mon_state_e;
endpackage

// File: rtl/crc16_ccitt_w16.sv
// One-step CRC-16/CCITT update over a 16-bit word, MSB first, no reflection.
module crc16_ccitt_w16
  import lcd_mon_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [15:0] data_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_acc;

  always_comb begin
    crc_acc = crc_i;
    for (int i = 15; i >= 0; i--) begin
      if (crc_acc[15] ^ data_i[i]) crc_acc = {crc_acc[14:0], 1'b0} ^ CRC_POLY;
      else                         crc_acc = {crc_acc[14:0], 1'b0};
    end
    crc_o = crc_acc;
  end

endmodule

// File: rtl/lcd_frame_monitor.sv
// Receive-side RGB565 LCD frame checker: line/frame geometry, lock tracking and per-frame CRC.
// The per-pixel CRC is compiled in only when LCD_MON_CRC_EN is defined; otherwise frame_crc is 0.
module lcd_frame_monitor
  import lcd_mon_pkg::*;
#(
  parameter int H_ACTIVE        = 480,
  parameter int V_ACTIVE        = 272,
  parameter int LOCK_FRAMES     = 2,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic        clk_pix,
  input  logic        rst_n,
  input  logic        lcd_de,
  input  logic        lcd_hsync,
  input  logic        lcd_vsync,
  input  logic [4:0]  lcd_r,
  input  logic [5:0]  lcd_g,
  input  logic [4:0]  lcd_b,
  output logic        frame_done,
  output logic [15:0] frame_crc,
  output logic [8:0]  frame_lines,
  output logic        err_hlen,
  output logic        err_vlen,
  output logic        locked,
  output logic [7:0]  frame_count
);

  localparam logic [PIX_W-1:0]  H_REQ    = PIX_W'(H_ACTIVE);
  localparam logic [LINE_W-1:0] V_REQ    = LINE_W'(V_ACTIVE);
  localparam logic [3:0]        LOCK_MAX = 4'(LOCK_FRAMES);

  function automatic logic [PIX_W-1:0] sat_inc_pix(input logic [PIX_W-1:0] v);
    return (&v) ? v : v + PIX_W'(1);
  endfunction

  function automatic logic [LINE_W-1:0] sat_inc_line(input logic [LINE_W-1:0] v);
    return (&v) ? v : v + LINE_W'(1);
  endfunction

  logic vs_norm, hs_norm;
  logic de_p1_q, de_p2_q, vs_p1_q, vs_p2_q, hs_p1_q;
  logic unused_hsync;

  assign vs_norm      = (SYNC_ACTIVE_LOW != 0) ? ~lcd_vsync : lcd_vsync;
  assign hs_norm      = (SYNC_ACTIVE_LOW != 0) ? ~lcd_hsync : lcd_hsync;
  assign unused_hsync = hs_p1_q;

  // S1 registers the pins, S2 holds the previous S1 value for edge detection
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      de_p1_q <= 1'b0;
      de_p2_q <= 1'b0;
      vs_p1_q <= 1'b0;
      vs_p2_q <= 1'b0;
      hs_p1_q <= 1'b0;
    end else begin
      de_p1_q <= lcd_de;
      de_p2_q <= de_p1_q;
      vs_p1_q <= vs_norm;
      vs_p2_q <= vs_p1_q;
      hs_p1_q <= hs_norm;
    end
  end

  mon_state_e        state_q, state_d;
  logic [PIX_W-1:0]  pix_q, pix_d, pix_inc;
  logic [LINE_W-1:0] line_q, line_d, line_inc;
  logic              hlen_q, hlen_d, hlen_inc;
  logic              vs_rise, de_fall, close_line, publish, clear_acc, frame_clean;
  logic [3:0]        lock_q, lock_d;

  assign vs_rise = vs_p1_q & ~vs_p2_q;
  // A zero count on a DE fall means the line was already closed by VSYNC the cycle before
  assign de_fall     = ~de_p1_q & de_p2_q & (pix_q != '0);
  assign close_line  = de_fall | (vs_rise & de_p1_q);
  assign pix_inc     = de_p1_q ? sat_inc_pix(pix_q) : pix_q;
  assign line_inc    = close_line ? sat_inc_line(line_q) : line_q;
  assign hlen_inc    = hlen_q | (close_line & (pix_inc != H_REQ));
  assign frame_clean = ~hlen_inc & (line_inc == V_REQ);

  always_comb begin
    state_d   = state_q;
    publish   = 1'b0;
    clear_acc = 1'b0;
    case (state_q)
      IDLE: if (vs_rise) begin
        state_d   = FRAME;
        clear_acc = 1'b1;
      end
      FRAME: if (vs_rise) begin
        publish   = 1'b1;
        clear_acc = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pix_d  = (clear_acc | close_line) ? '0 : pix_inc;
    line_d = clear_acc ? '0 : line_inc;
    hlen_d = clear_acc ? 1'b0 : hlen_inc;
    if (!frame_clean)           lock_d = 4'd0;
    else if (lock_q == LOCK_MAX) lock_d = lock_q;
    else                        lock_d = lock_q + 4'd1;
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pix_q   <= '0;
      line_q  <= '0;
      hlen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      line_q  <= line_d;
      hlen_q  <= hlen_d;
    end
  end

  logic       done_q, err_h_q, err_v_q;
  logic [8:0] lines_q;
  logic [7:0] cnt_q;

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      done_q  <= 1'b0;
      lines_q <= '0;
      err_h_q <= 1'b0;
      err_v_q <= 1'b0;
      cnt_q   <= '0;
      lock_q  <= '0;
    end else begin
      done_q <= publish;
      if (publish) begin
        lines_q <= line_inc;
        err_h_q <= hlen_inc;
        err_v_q <= (line_inc != V_REQ);
        cnt_q   <= cnt_q + 8'd1;
        lock_q  <= lock_d;
      end
    end
  end

`ifdef LCD_MON_CRC_EN
  logic [15:0] pix_p1_q, crc_q, crc_step, crc_inc, crc_out_q;

  crc16_ccitt_w16 u_crc (
    .crc_i  (crc_q),
    .data_i (pix_p1_q),
    .crc_o  (crc_step)
  );

  assign crc_inc = de_p1_q ? crc_step : crc_q;

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      pix_p1_q  <= '0;
      crc_q     <= CRC_INIT;
      crc_out_q <= '0;
    end else begin
      pix_p1_q <= {lcd_r, lcd_g, lcd_b};
      crc_q    <= clear_acc ? CRC_INIT : crc_inc;
      if (publish) crc_out_q <= crc_inc;
    end
  end

  assign frame_crc = crc_out_q;
`else
  logic unused_pixel;
  assign unused_pixel = ^{lcd_r, lcd_g, lcd_b};
  assign frame_crc    = 16'h0000;
`endif

  assign frame_done  = done_q;
  assign frame_lines = lines_q;
  assign err_hlen    = err_h_q;
  assign err_vlen    = err_v_q;
  assign locked      = (lock_q == LOCK_MAX);
  assign frame_count = cnt_q;

endmodule

// File: tb/tb_lcd_frame_monitor.sv
// Directed bench for lcd_frame_monitor using a reduced 4x4 geometry.
module tb_lcd_frame_monitor;
  localparam int H = 4;
  localparam int V = 4;

  logic        clk_pix = 1'b0;
  logic        rst_n = 1'b0;
  logic        lcd_de = 1'b0, lcd_hsync = 1'b1, lcd_vsync = 1'b1;
  logic [4:0]  lcd_r = '0;
  logic [5:0]  lcd_g = '0;
  logic [4:0]  lcd_b = '0;
  logic        frame_done, err_hlen, err_vlen, locked;
  logic [15:0] frame_crc;
  logic [8:0]  frame_lines;
  logic [7:0]  frame_count;

  lcd_frame_monitor #(.H_ACTIVE(H), .V_ACTIVE(V), .LOCK_FRAMES(2), .SYNC_ACTIVE_LOW(1)) dut (
    .clk_pix(clk_pix), .rst_n(rst_n), .lcd_de(lcd_de), .lcd_hsync(lcd_hsync),
    .lcd_vsync(lcd_vsync), .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b),
    .frame_done(frame_done), .frame_crc(frame_crc), .frame_lines(frame_lines),
    .err_hlen(err_hlen), .err_vlen(err_vlen), .locked(locked), .frame_count(frame_count)
  );

  always #5 clk_pix = ~clk_pix;

  int checks = 0, errors = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, vs_cyc = 0, width_err = 0, got_done = 0;
  logic        prev_done = 1'b0;
  logic [15:0] m_crc = 16'hFFFF, last_crc = 16'h0;
  bit          use_pat = 0;
  logic [15:0] pat [4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};

  always @(posedge clk_pix) cyc <= cyc + 1;

  always @(negedge clk_pix) begin
    if (frame_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      if (prev_done) width_err++;
    end
    prev_done = (frame_done === 1'b1);
  end

  function automatic logic [15:0] model_crc(input logic [15:0] crc, input logic [15:0] d);
    logic [15:0] c, x;
    logic        top;
    c = crc;
    x = d;
    for (int i = 0; i < 16; i++) begin
      top = c[15] ^ x[15];
      c   = c << 1;
      if (top) c = c ^ 16'h1021;
      x = x << 1;
    end
    return c;
  endfunction

  function automatic logic [15:0] exp_crc();
`ifdef LCD_MON_CRC_EN
    return last_crc;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic drive(input logic de, input logic vs, input logic hs, input logic [15:0] px);
    @(posedge clk_pix);
    #1;
    lcd_de    = de;
    lcd_vsync = ~vs;
    lcd_hsync = ~hs;
    {lcd_r, lcd_g, lcd_b} = px;
  endtask

  task automatic send_line(input int n);
    logic [15:0] px;
    for (int k = 0; k < n; k++) begin
      px    = use_pat ? pat[k % 4] : 16'h0000;
      m_crc = model_crc(m_crc, px);
      drive(1'b1, 1'b0, 1'b0, px);
    end
    drive(1'b0, 1'b0, 1'b1, 16'h0);
    drive(1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic vsync_edge();
    drive(1'b0, 1'b1, 1'b0, 16'h0);
    vs_cyc   = cyc;
    last_crc = m_crc;
    m_crc    = 16'hFFFF;
    drive(1'b0, 1'b1, 1'b0, 16'h0);
    repeat (4) drive(1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic send_frame(input int nlines, input int bad_line, input int bad_len, input int open_pix);
    int          d0;
    logic [15:0] px;
    d0 = done_cnt;
    for (int l = 0; l < nlines; l++) send_line((l == bad_line) ? bad_len : H);
    if (open_pix > 0) begin
      for (int k = 0; k < open_pix; k++) begin
        px    = use_pat ? pat[k % 4] : 16'h0000;
        m_crc = model_crc(m_crc, px);
        if (k == open_pix - 1) begin
          drive(1'b1, 1'b1, 1'b0, px);
          vs_cyc = cyc;
        end else begin
          drive(1'b1, 1'b0, 1'b0, px);
        end
      end
      last_crc = m_crc;
      m_crc    = 16'hFFFF;
      drive(1'b0, 1'b1, 1'b0, 16'h0);
      repeat (4) drive(1'b0, 1'b0, 1'b0, 16'h0);
    end else begin
      vsync_edge();
    end
    got_done = done_cnt - d0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) drive(1'b0, 1'b0, 1'b0, 16'h0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({frame_done, frame_crc, frame_lines, err_hlen, err_vlen, locked, frame_count} !== 38'd0) begin errors++; $display("FAIL reset_outputs got done=%b crc=%h lines=%0d eh=%b ev=%b lk=%b cnt=%0d exp all 0", frame_done, frame_crc, frame_lines, err_hlen, err_vlen, locked, frame_count); end
  endtask

  task automatic test_zero_frames();
    int d0;
    use_pat = 0;
    d0 = done_cnt;
    vsync_edge();
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL idle_no_pulse got %0d exp 0", done_cnt - d0); end
    send_frame(V, -1, 0, 0);
    checks++; if (got_done !== 1) begin errors++; $display("FAIL zero_done got %0d exp 1", got_done); end
    checks++; if (done_cyc - vs_cyc !== 2) begin errors++; $display("FAIL zero_latency got %0d exp 2", done_cyc - vs_cyc); end
    checks++; if (frame_lines !== 9'd4) begin errors++; $display("FAIL zero_lines got %0d exp 4", frame_lines); end
    checks++; if ({err_hlen, err_vlen} !== 2'b00) begin errors++; $display("FAIL zero_errs got %b%b exp 00", err_hlen, err_vlen); end
    checks++; if (frame_count !== 8'd1) begin errors++; $display("FAIL zero_count got %0d exp 1", frame_count); end
    checks++; if (frame_crc !== exp_crc()) begin errors++; $display("FAIL zero_crc got %h exp %h", frame_crc, exp_crc()); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL zero_locked got %b exp 0", locked); end
  endtask

  task automatic test_pattern_crc();
    use_pat = 1;
    send_frame(V, -1, 0, 0);
    checks++; if (frame_crc !== exp_crc()) begin errors++; $display("FAIL pat_crc1 got %h exp %h", frame_crc, exp_crc()); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL pat_locked got %b exp 1", locked); end
    send_frame(V, -1, 0, 0);
    checks++; if (frame_crc !== exp_crc()) begin errors++; $display("FAIL pat_crc2 got %h exp %h", frame_crc, exp_crc()); end
    checks++; if (frame_count !== 8'd3) begin errors++; $display("FAIL pat_count got %0d exp 3", frame_count); end
  endtask

  task automatic test_hlen_error();
    send_frame(V, 1, H - 1, 0);
    checks++; if ({err_hlen, err_vlen, locked} !== 3'b100) begin errors++; $display("FAIL hlen_flags got eh=%b ev=%b lk=%b exp 1 0 0", err_hlen, err_vlen, locked); end
    checks++; if (frame_lines !== 9'd4) begin errors++; $display("FAIL hlen_lines got %0d exp 4", frame_lines); end
    send_frame(V, -1, 0, 0);
    checks++; if ({err_hlen, locked} !== 2'b00) begin errors++; $display("FAIL relock1 got eh=%b lk=%b exp 0 0", err_hlen, locked); end
    send_frame(V, -1, 0, 0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL relock2 got %b exp 1", locked); end
  endtask

  task automatic test_vlen_open_line();
    send_frame(V + 1, -1, 0, 0);
    checks++; if ({err_hlen, err_vlen, locked} !== 3'b010) begin errors++; $display("FAIL vlen_flags got eh=%b ev=%b lk=%b exp 0 1 0", err_hlen, err_vlen, locked); end
    checks++; if (frame_lines !== 9'd5) begin errors++; $display("FAIL vlen_lines got %0d exp 5", frame_lines); end
    send_frame(V - 1, -1, 0, 3);
    checks++; if (got_done !== 1) begin errors++; $display("FAIL open_done got %0d exp 1", got_done); end
    checks++; if (frame_lines !== 9'd4) begin errors++; $display("FAIL open_lines got %0d exp 4", frame_lines); end
    checks++; if ({err_hlen, err_vlen} !== 2'b10) begin errors++; $display("FAIL open_flags got eh=%b ev=%b exp 1 0", err_hlen, err_vlen); end
    checks++; if (frame_crc !== exp_crc()) begin errors++; $display("FAIL open_crc got %h exp %h", frame_crc, exp_crc()); end
    send_frame(V, -1, 0, 0);
    checks++; if ({frame_lines, err_hlen, err_vlen} !== {9'd4, 2'b00}) begin errors++; $display("FAIL after_open got lines=%0d eh=%b ev=%b exp 4 0 0", frame_lines, err_hlen, err_vlen); end
  endtask

  task automatic test_line_saturation();
    send_frame(515, -1, 0, 0);
    checks++; if (frame_lines !== 9'd511) begin errors++; $display("FAIL sat_lines got %0d exp 511", frame_lines); end
    checks++; if (err_vlen !== 1'b1) begin errors++; $display("FAIL sat_vlen got %b exp 1", err_vlen); end
  endtask

  task automatic test_reset_midframe();
    send_line(H);
    send_line(H);
    @(posedge clk_pix);
    #1;
    rst_n = 1'b0;
    #2;
    checks++; if ({frame_done, frame_crc, frame_lines, err_hlen, err_vlen, locked, frame_count} !== 38'd0) begin errors++; $display("FAIL midrst_outputs got crc=%h lines=%0d eh=%b ev=%b lk=%b cnt=%0d exp all 0", frame_crc, frame_lines, err_hlen, err_vlen, locked, frame_count); end
    @(posedge clk_pix);
    #1;
    rst_n = 1'b1;
    send_frame(2, -1, 0, 0);
    checks++; if (got_done !== 0) begin errors++; $display("FAIL midrst_no_pulse got %0d exp 0", got_done); end
    send_frame(V, -1, 0, 0);
    checks++; if (got_done !== 1) begin errors++; $display("FAIL midrst_done got %0d exp 1", got_done); end
    checks++; if ({frame_count, frame_lines, err_hlen, err_vlen} !== {8'd1, 9'd4, 2'b00}) begin errors++; $display("FAIL midrst_frame got cnt=%0d lines=%0d eh=%b ev=%b exp 1 4 0 0", frame_count, frame_lines, err_hlen, err_vlen); end
    checks++; if (frame_crc !== exp_crc()) begin errors++; $display("FAIL midrst_crc got %h exp %h", frame_crc, exp_crc()); end
  endtask

  task automatic test_frame_wrap();
    do_reset();
    vsync_edge();
    for (int i = 1; i <= 256; i++) begin
      send_frame(V, -1, 0, 0);
      if (i >= 2) begin
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL wrap_locked frame %0d got %b exp 1", i, locked); end
      end
      if (i == 255) begin
        checks++; if (frame_count !== 8'd255) begin errors++; $display("FAIL wrap_count255 got %0d exp 255", frame_count); end
      end
    end
    checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL wrap_count got %0d exp 0", frame_count); end
  endtask

  task automatic test_pulse_width();
    checks++; if (width_err !== 0) begin errors++; $display("FAIL done_width got %0d wide pulses exp 0", width_err); end
  endtask

  initial begin
    test_reset();
    test_zero_frames();
    test_pattern_crc();
    test_hlen_error();
    test_vlen_open_line();
    test_line_saturation();
    test_reset_midframe();
    test_frame_wrap();
    test_pulse_width();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
